reg_list_store_seq: RTL and testbench

Multi-register store sequencer for the Cortex-M0 core, executing PUSH and STMIA. On a decoded start it walks the register list lowest-first, reads each register through a read port of `coreRegisters`, and issues one word write per register to the data-memory interface. It finishes with a single base-register writeback: SP for PUSH, Rn for STMIA.

---
 rtl/reg_list_store_seq_pkg.sv | 20 ++
 rtl/reg_list_popcount.sv | 15 +
 rtl/reg_list_store_seq.sv | 119 +++++++++++
 tb/tb_reg_list_store_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_list_store_seq_pkg.sv
// Shared constants and state encoding for the PUSH/STMIA store sequencer.
package reg_list_store_seq_pkg;

  typedef enum logic [1:0] {
    RLS_IDLE = 2'd0,
    RLS_SEL  = 2'd1,
    RLS_XFER = 2'd2,
    RLS_WB   = 2'd3
  } rls_state_e;

  localparam logic [3:0]  SP_I       = 4'd13;
  localparam logic [3:0]  LR_I       = 4'd14;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Byte span of n stored words.
  function automatic logic [31:0] list_bytes(input logic [3:0] n);
    return {26'd0, n, 2'b00};
  endfunction

endpackage

// File: rtl/reg_list_popcount.sv
// Number of set bits in the 9-entry pending list ({LR, R7..R0}).
module reg_list_popcount (
  input  logic [8:0] bits,
  output logic [3:0] count
);

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves count unassigned (no latch).
    count = 4'd0;
    for (int i = 0; i < 9; i++) begin
      count = count + 4'(bits[i]);
    end
  end

endmodule

// File: rtl/reg_list_store_seq.sv
// Multi-register store sequencer: walks the pending list lowest-first, issues one
// word write per register, then performs a single base-register writeback.
module reg_list_store_seq
  import reg_list_store_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_push,
  input  logic [7:0]  reg_list,
  input  logic        push_lr,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_val,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        done
);

  rls_state_e  state;
  logic [8:0]  pending;
  logic [8:0]  start_list;
  logic [3:0]  start_count;
  logic [31:0] span;
  logic [8:0]  pending_rest;

  // LR can only join the list for PUSH; bit 8 stands for LR.
  assign start_list   = {push_lr & op_push, reg_list};
  assign span         = list_bytes(start_count);
  assign pending_rest = pending & (pending - 9'd1);
  assign busy         = (state != RLS_IDLE);

  reg_list_popcount u_popcount (
    .bits  (start_list),
    .count (start_count)
  );

  // Lowest set pending bit wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    rd_addr = 4'd0;
    if (state == RLS_SEL) begin
      for (int i = 8; i >= 0; i--) begin
        if (pending[i]) rd_addr = (i == 8) ? LR_I : 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      state     <= RLS_IDLE;
      pending   <= 9'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      wb_en     <= 1'b0;
      wb_addr   <= 4'd0;
      wb_data   <= 32'd0;
      done      <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        RLS_IDLE: begin
          if (start) begin
            pending <= start_list;
            if (op_push) begin
              mem_addr <= base_val - span;
              wb_data  <= base_val - span;
              wb_addr  <= SP_I;
            end else begin
              mem_addr <= base_val;
              wb_data  <= base_val + span;
              wb_addr  <= base_reg;
            end
            if (start_count == 4'd0) begin
              state <= RLS_WB;
              wb_en <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= RLS_SEL;
            end
          end
        end
        RLS_SEL: begin
          mem_wdata <= rd_data;
          mem_req   <= 1'b1;
          state     <= RLS_XFER;
        end
        RLS_XFER: begin
          if (mem_ack) begin
            pending  <= pending_rest;
            mem_addr <= mem_addr + WORD_BYTES;
            mem_req  <= 1'b0;
            if (pending_rest == 9'd0) begin
              state <= RLS_WB;
              wb_en <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= RLS_SEL;
            end
          end
        end
        RLS_WB: begin
          state <= RLS_IDLE;
        end
        default: state <= RLS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_list_store_seq.sv
// Directed bench for reg_list_store_seq: register-file model, memory responder
// with configurable wait states, and hand-computed expected writes/writebacks.
module tb_reg_list_store_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_push;
  logic [7:0]  reg_list;
  logic        push_lr;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_list_store_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_push   (op_push),
    .reg_list  (reg_list),
    .push_lr   (push_lr),
    .base_reg  (base_reg),
    .base_val  (base_val),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .busy      (busy),
    .done      (done)
  );

  // Register file model, combinational read.
  logic [31:0] regs [16];
  assign rd_data = regs[rd_addr];

  // Memory responder: acks after ack_wait cycles of mem_req; ack_force acks unconditionally.
  int   ack_wait  = 0;
  logic ack_force = 1'b0;
  int   req_cnt   = 0;
  always @(posedge clk) begin
    if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
    else                     req_cnt <= 0;
  end
  assign mem_ack = ack_force | (mem_req && (req_cnt >= ack_wait));

  // Transaction monitor, sampled on the falling edge.
  logic [31:0] w_addr [16];
  logic [31:0] w_data [16];
  int          w_n = 0, wb_n = 0, req_n = 0, unstable = 0;
  logic [3:0]  last_wb_addr = 4'd0;
  logic [31:0] last_wb_data = 32'd0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;

  always @(negedge clk) begin
    if (mem_req && prev_req && (mem_addr !== prev_addr || mem_wdata !== prev_data))
      unstable++;
    if (mem_req) req_n++;
    if (mem_req && mem_ack && w_n < 16) begin
      w_addr[w_n] = mem_addr;
      w_data[w_n] = mem_wdata;
      w_n++;
    end
    if (wb_en) begin
      wb_n++;
      last_wb_addr = wb_addr;
      last_wb_data = wb_data;
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_data = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    w_n      = 0;
    wb_n     = 0;
    req_n    = 0;
    unstable = 0;
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < w_n) begin
      check($sformatf("%s_addr%0d", tag, idx), w_addr[idx], a);
      check($sformatf("%s_data%0d", tag, idx), w_data[idx], d);
    end else begin
      check($sformatf("%s_missing%0d", tag, idx), 32'(w_n), 32'(idx + 1));
    end
  endtask

  // Called at a falling edge. Cycle 0 is the cycle carrying start; done_at is the
  // cycle in which done is high, or -1 if it never rises within the budget.
  task automatic run(input logic op, input logic [7:0] list, input logic lr,
                     input logic [3:0] breg, input logic [31:0] bval,
                     input int restart_at, output int done_at);
    clear_log();
    op_push  = op;
    reg_list = list;
    push_lr  = lr;
    base_reg = breg;
    base_val = bval;
    start    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == restart_at) begin
        start    = 1'b1;
        reg_list = 8'hFF;
        base_val = 32'hDEAD_0000;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  int d;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h100 + 32'(i);
    regs[0]  = 32'h0;
    regs[14] = 32'hFFFF_FFFF;
    rst      = 1'b0;
    start    = 1'b0;
    op_push  = 1'b0;
    reg_list = 8'h00;
    push_lr  = 1'b0;
    base_reg = 4'd0;
    base_val = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_mem_req",  32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wdata",    mem_wdata, 32'd0);
    check("rst_wb_en",    32'(wb_en), 32'd0);
    check("rst_wb_data",  wb_data, 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_rd_addr",  32'(rd_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // PUSH {R0,R1,LR}, SP=0x1000; base_reg must be ignored.
    run(1'b1, 8'h03, 1'b1, 4'd7, 32'h1000, 0, d);
    check("push_nwr", 32'(w_n), 32'd3);
    check_wr("push", 0, 32'h0FF4, 32'h0);
    check_wr("push", 1, 32'h0FF8, 32'h101);
    check_wr("push", 2, 32'h0FFC, 32'hFFFF_FFFF);
    check("push_wb_n",    32'(wb_n), 32'd1);
    check("push_wb_addr", 32'(last_wb_addr), 32'd13);
    check("push_wb_data", last_wb_data, 32'h0FF4);
    check("push_done_at", 32'(d), 32'd7);
    check("push_idle",    32'(busy), 32'd0);

    // STMIA R4!,{R1,R2,R3}
    run(1'b0, 8'h0E, 1'b0, 4'd4, 32'h2000, 0, d);
    check("stm_nwr", 32'(w_n), 32'd3);
    check_wr("stm", 0, 32'h2000, 32'h101);
    check_wr("stm", 1, 32'h2004, 32'h102);
    check_wr("stm", 2, 32'h2008, 32'h103);
    check("stm_wb_addr", 32'(last_wb_addr), 32'd4);
    check("stm_wb_data", last_wb_data, 32'h200C);
    check("stm_done_at", 32'(d), 32'd7);

    // STMIA R5!,{R2} with three wait states: 1 SEL + 4 XFER cycles, done in cycle 6.
    ack_wait = 3;
    run(1'b0, 8'h04, 1'b0, 4'd5, 32'h3000, 0, d);
    ack_wait = 0;
    check("wait_req_cycles", 32'(req_n), 32'd4);
    check("wait_unstable",   32'(unstable), 32'd0);
    check("wait_nwr",        32'(w_n), 32'd1);
    check_wr("wait", 0, 32'h3000, 32'h102);
    check("wait_wb_data",    last_wb_data, 32'h3004);
    check("wait_done_at",    32'(d), 32'd6);

    // Empty list, with a stray ack held high throughout that must be ignored.
    ack_force = 1'b1;
    run(1'b0, 8'h00, 1'b0, 4'd6, 32'h4444, 0, d);
    ack_force = 1'b0;
    check("empty_req_cycles", 32'(req_n), 32'd0);
    check("empty_nwr",        32'(w_n), 32'd0);
    check("empty_done_at",    32'(d), 32'd1);
    check("empty_wb_n",       32'(wb_n), 32'd1);
    check("empty_wb_addr",    32'(last_wb_addr), 32'd6);
    check("empty_wb_data",    last_wb_data, 32'h4444);

    // STMIA R2!,{R0,R1} with a second start in cycle 2 while busy.
    run(1'b0, 8'h03, 1'b0, 4'd2, 32'h5000, 2, d);
    check("busy_nwr", 32'(w_n), 32'd2);
    check_wr("busy", 0, 32'h5000, 32'h0);
    check_wr("busy", 1, 32'h5004, 32'h101);
    check("busy_wb_data", last_wb_data, 32'h5008);
    check("busy_done_at", 32'(d), 32'd5);
    repeat (3) @(negedge clk);
    check("busy_no_restart", 32'(busy), 32'd0);
    check("busy_nwr_after",  32'(w_n), 32'd2);

    // Reset pulled during XFER.
    clear_log();
    ack_wait = 5;
    op_push  = 1'b0;
    reg_list = 8'h07;
    push_lr  = 1'b0;
    base_reg = 4'd3;
    base_val = 32'h7000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
    check("rstx_req_seen", 32'(mem_req), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rstx_mem_req",  32'(mem_req), 32'd0);
    check("rstx_busy",     32'(busy), 32'd0);
    check("rstx_mem_addr", mem_addr, 32'd0);
    rst      = 1'b1;
    ack_wait = 0;
    repeat (6) @(negedge clk);
    check("rstx_wb_n", 32'(wb_n), 32'd0);
    check("rstx_nwr",  32'(w_n), 32'd0);

    // STMIA R1!,{R1,R2} with R1 at the top of memory: old R1 stored, writeback wraps.
    regs[1] = 32'hFFFF_FFF8;
    run(1'b0, 8'h06, 1'b0, 4'd1, 32'hFFFF_FFF8, 0, d);
    check("wrap_nwr", 32'(w_n), 32'd2);
    check_wr("wrap", 0, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    check_wr("wrap", 1, 32'hFFFF_FFFC, 32'h102);
    check("wrap_wb_addr", 32'(last_wb_addr), 32'd1);
    check("wrap_wb_data", last_wb_data, 32'h0);
    check("wrap_done_at", 32'(d), 32'd5);

    // push_lr with STMIA: LR must not be stored.
    run(1'b0, 8'h01, 1'b1, 4'd3, 32'h6000, 0, d);
    check("nolr_nwr", 32'(w_n), 32'd1);
    check_wr("nolr", 0, 32'h6000, 32'h0);
    check("nolr_wb_data", last_wb_data, 32'h6004);
    check("nolr_done_at", 32'(d), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
